// File: rtl/lut_cfg_ctrl.sv
// Serial truth-table loader for a 4-input mux-tree LUT: shadow load, atomic commit to the active table.
// Optional even-parity trailer bit on each load when LUT_CFG_PARITY_EN is defined.
//
// state | meaning
// IDLE  | waiting for cfg_start; table_out holds the committed table
// LOAD  | shifting serial bits into the shadow register
// ARMED | full table held in shadow, waiting for commit
module lut_cfg_ctrl #(
  parameter int SEL_W = 4,
  parameter int CNT_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic                    cfg_bit,
  input  logic                    cfg_valid,
  input  logic                    commit,
  output logic [(2**SEL_W)-1:0]   table_out,
  output logic                    busy,
  output logic                    armed,
  output logic                    done,
  output logic                    err
);

  localparam int TBL_W = 2**SEL_W;
`ifdef LUT_CFG_PARITY_EN
  localparam int NBITS = TBL_W + 1;
`else
  localparam int NBITS = TBL_W;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

  state_t             state, state_nxt;
  logic [TBL_W-1:0]   shadow, shadow_nxt;
  logic [TBL_W-1:0]   table_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               done_nxt, err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      table_out <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      armed     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      table_out <= table_nxt;
      cnt       <= cnt_nxt;
      busy      <= (state_nxt == LOAD);
      armed     <= (state_nxt == ARMED);
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    table_nxt  = table_out;
    cnt_nxt    = cnt;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nxt  = LOAD;
          cnt_nxt    = '0;
          shadow_nxt = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          // restart drops any bit presented in the same cycle
          cnt_nxt    = '0;
          shadow_nxt = '0;
          err_nxt    = 1'b1;
        end else begin
          if (commit) err_nxt = 1'b1;
          if (cfg_valid) begin
            cnt_nxt = cnt + CNT_W'(1);
`ifdef LUT_CFG_PARITY_EN
            if (cnt == LAST) begin
              // shadow is complete here, so parity is taken straight from it
              if ((^shadow) != cfg_bit) begin
                state_nxt  = IDLE;
                shadow_nxt = '0;
                err_nxt    = 1'b1;
              end else begin
                state_nxt = ARMED;
              end
            end else begin
              shadow_nxt = {shadow[TBL_W-2:0], cfg_bit};
            end
`else
            shadow_nxt = {shadow[TBL_W-2:0], cfg_bit};
            if (cnt == LAST) state_nxt = ARMED;
`endif
          end
        end
      end
      ARMED: begin
        if (commit) begin
          table_nxt = shadow;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (cfg_start) begin
          state_nxt  = LOAD;
          cnt_nxt    = '0;
          shadow_nxt = '0;
          err_nxt    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lut_cfg_ctrl.sv
// Directed bench for lut_cfg_ctrl; committed tables are checked through a scoreboard queue on done.
// Honours LUT_CFG_PARITY_EN the same way as the design.
module tb_lut_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_bit = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        commit = 1'b0;
  logic [15:0] table_out;
  logic        busy, armed, done, err;

  int n_assert = 0;
  int n_fail = 0;
  int done_seen = 0;
  int err_seen = 0;
  logic [15:0] sb_q[$];

  lut_cfg_ctrl dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_bit(cfg_bit),
    .cfg_valid(cfg_valid), .commit(commit), .table_out(table_out),
    .busy(busy), .armed(armed), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic mux_model(input logic [15:0] tbl, input logic [3:0] sel);
    logic [3:0] k;
    k = {sel[0], sel[1], sel[2], sel[3]};
    return tbl[15 - k];
  endfunction

  task automatic tick();
    logic [15:0] exp_tbl;
    @(posedge clk);
    #1;
    if (done) begin
      check("sb_nonempty", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        exp_tbl = sb_q.pop_front();
        check("sb_table", table_out, exp_tbl);
      end
    end
    if (done && err) check("err_done_excl", {done, err}, 2'b00);
    done_seen += done;
    err_seen  += err;
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] val, input int hi, input int lo, input int gap);
    for (int i = hi; i >= lo; i--) begin
      send_bit(val[i]);
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic send_par(input logic [15:0] val, input logic bad);
`ifdef LUT_CFG_PARITY_EN
    check("armed_before_parity", armed, 0);
    send_bit((^val) ^ bad);
`endif
  endtask

  task automatic load(input logic [15:0] val, input int gap);
    start_load();
    send_bits(val, 15, 0, gap);
    send_par(val, 1'b0);
  endtask

  task automatic do_commit(input logic [15:0] exp_tbl);
    sb_q.push_back(exp_tbl);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("done_on_commit", done, 1);
  endtask

  initial begin
    int d0, e0;
    // reset state
    tick(); tick();
    check("rst_table", table_out, 16'h0000);
    check("rst_flags", {busy, armed, done, err}, 4'b0000);
    rst = 1'b0;
    tick();

    // 1: populate, then reset mid-load after 7 bits
    load(16'hFFFF, 0);
    check("t1_armed", armed, 1);
    do_commit(16'hFFFF);
    start_load();
    send_bits(16'h5555, 15, 9, 0);
    check("t1_busy_mid", busy, 1);
    rst = 1'b1;
    #2;
    check("t1_rst_table", table_out, 16'h0000);
    check("t1_rst_busy", busy, 0);
    check("t1_rst_armed", armed, 0);
    rst = 1'b0;
    tick();
    load(16'hA5C3, 0);
    do_commit(16'hA5C3);
    check("t1_table", table_out, 16'hA5C3);
    tick();
    check("t1_done_clear", done, 0);

    // 2: single-hot table and mux mapping
    load(16'h8000, 0);
    do_commit(16'h8000);
    for (int s = 0; s < 16; s++)
      check($sformatf("t2_mux_sel%0d", s), mux_model(table_out, 4'(s)), (s == 0));
    check("t2_mux_map", mux_model(16'h4000, 4'b1000), 1);

    // 3: gappy load; table held until commit; one done
    start_load();
    send_bits(16'h6996, 15, 1, 2);
    check("t3_not_armed", armed, 0);
    send_bit(1'b0);
    send_par(16'h6996, 1'b0);
    check("t3_armed", armed, 1);
    check("t3_busy", busy, 0);
    tick(); tick();
    check("t3_table_hold", table_out, 16'h8000);
    d0 = done_seen;
    do_commit(16'h6996);
    tick(); tick();
    check("t3_done_once", done_seen - d0, 1);
    check("t3_table", table_out, 16'h6996);

    // 4: restart after 9 bits
    e0 = err_seen;
    start_load();
    send_bits(16'hFFFF, 15, 7, 0);
    start_load();
    check("t4_err_pulse", err, 1);
    check("t4_busy", busy, 1);
    send_bits(16'h1234, 15, 0, 0);
    send_par(16'h1234, 1'b0);
    do_commit(16'h1234);
    check("t4_err_once", err_seen - e0, 1);
    check("t4_table", table_out, 16'h1234);

    // 5: commit ignored in IDLE and LOAD; commit beats cfg_start in ARMED
    e0 = err_seen;
    commit = 1'b1; tick(); commit = 1'b0;
    check("t5_idle_done", done, 0);
    check("t5_idle_err", err_seen - e0, 0);
    check("t5_idle_table", table_out, 16'h1234);
    start_load();
    send_bits(16'hBEEF, 15, 13, 0);
    commit = 1'b1; tick(); commit = 1'b0;
    check("t5_load_err", err, 1);
    check("t5_load_done", done, 0);
    check("t5_load_busy", busy, 1);
    send_bits(16'hBEEF, 12, 0, 0);
    send_par(16'hBEEF, 1'b0);
    check("t5_table_before", table_out, 16'h1234);
    check("t5_armed", armed, 1);
    e0 = err_seen;
    sb_q.push_back(16'hBEEF);
    commit = 1'b1; cfg_start = 1'b1;
    tick();
    commit = 1'b0; cfg_start = 1'b0;
    check("t5_both_done", done, 1);
    check("t5_both_err", err, 0);
    check("t5_both_state", {busy, armed}, 2'b00);
    tick();
    check("t5_idle_after", {busy, armed, err_seen - e0 == 0}, 3'b001);

`ifdef LUT_CFG_PARITY_EN
    // 6: parity good then bad
    start_load();
    send_bits(16'h0001, 15, 0, 0);
    send_bit(1'b1);
    check("t6_good_armed", armed, 1);
    do_commit(16'h0001);
    start_load();
    send_bits(16'h0001, 15, 0, 0);
    send_bit(1'b0);
    check("t6_bad_err", err, 1);
    check("t6_bad_state", {busy, armed}, 2'b00);
    check("t6_bad_table", table_out, 16'h0001);
    commit = 1'b1; tick(); commit = 1'b0;
    check("t6_no_commit", done, 0);
`endif

    tick();
    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
